// File: rtl/mux_rr_stream_if.sv
// Purpose : stream bundle for mux_rr_stream. It carries N_CH producer lanes in and one sink lane out.
// Latency : none. This is a wiring-only bundle.
// Backpressure: in_ready per lane, out_ready from the sink.
//
// Signals
//   in_valid  [N_CH]        per-channel valid from producers
//   in_data   [N_CH*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N_CH]        per-channel accept back to producers
//   out_valid               output register holds a word
//   out_ready               sink accepts the word this cycle
//   out_data  [WIDTH]       registered output word
//   out_ch    [CH_W]        source channel of out_data
// Modports
//   slave  : the multiplexer's view (consumes inputs, drives outputs)
//   master : the environment's view (producers plus sink)
interface mux_rr_stream_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) ();
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch
    );
endinterface

// File: rtl/mux_rr_stream.sv
// Purpose : N-channel stream mux with manual-select or round-robin grant and a registered output stage.
// Latency : 1 cycle from input handshake to out_valid. Sustains one word per cycle.
// Backpressure: a held word stalls all in_ready. The word drains and is replaced on the same edge.
//
// Ports
//   clk_i    rising-edge clock
//   reset_i  synchronous, active-high reset
//   mode_i   0 = manual select by sel_i, 1 = round-robin among valid channels
//   sel_i    manual-mode channel index (values >= N_CH never grant)
//   bus      mux_rr_stream_if.slave: in_valid/in_data/in_ready, out_valid/out_ready/out_data/out_ch
module mux_rr_stream #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            mode_i,
    input  logic [CH_W-1:0] sel_i,
    mux_rr_stream_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CH_W-1:0]  out_ch_q,    out_ch_d;
    // last_q is the most recent round-robin winner. The scan starts just above it.
    logic [CH_W-1:0]  last_q,      last_d;

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
    logic             load;
    logic             man_vld;
    logic [CH_W-1:0]  man_idx;
    logic             rr_hi_vld;
    logic [CH_W-1:0]  rr_hi_idx;
    logic             rr_lo_vld;
    logic [CH_W-1:0]  rr_lo_idx;
    logic             rr_vld;
    logic [CH_W-1:0]  rr_idx;
    logic             grant_vld;
    logic [CH_W-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_dat;

    // The output register can accept a word when it is empty or draining this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // Manual select. Matching sel_i against every legal index means an
    // out-of-range sel_i (non-power-of-two N_CH) never matches. So it never grants.
    always_comb begin
        man_vld = 1'b0;
        man_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_i == CH_W'(i) && bus.in_valid[i]) begin
                man_vld = 1'b1;
                man_idx = CH_W'(i);
            end
        end
    end

    // Round-robin without a modulo. The lowest valid channel above last_q wins.
    // If there is none, the scan wraps, and the lowest valid channel overall wins.
    // Both loops run downward, so the lowest match is written last.
    always_comb begin
        rr_hi_vld = 1'b0;
        rr_hi_idx = '0;
        rr_lo_vld = 1'b0;
        rr_lo_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.in_valid[i] && (CH_W'(i) > last_q)) begin
                rr_hi_vld = 1'b1;
                rr_hi_idx = CH_W'(i);
            end
            if (bus.in_valid[i]) begin
                rr_lo_vld = 1'b1;
                rr_lo_idx = CH_W'(i);
            end
        end
    end

    assign rr_vld    = rr_hi_vld || rr_lo_vld;
    assign rr_idx    = rr_hi_vld ? rr_hi_idx : rr_lo_idx;

    // mode_i and sel_i act on this cycle's grant. A held word is not affected.
    assign grant_vld = mode_i ? rr_vld : man_vld;
    assign grant_idx = mode_i ? rr_idx : man_idx;

    // Data of the granted channel.
    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                grant_dat = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // At most one ready bit is set, and only toward a valid channel, because
    // grant_vld already implies that in_valid[grant_idx] is high.
    always_comb begin
        bus.in_ready = '0;
        if (!reset_i && load && grant_vld) begin
            for (int i = 0; i < N_CH; i++) begin
                if (grant_idx == CH_W'(i)) begin
                    bus.in_ready[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (load) begin
            if (grant_vld) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_dat;
                out_ch_d    = grant_idx;
                // Manual grants leave the round-robin pointer alone.
                if (mode_i) begin
                    last_d = grant_idx;
                end
            end else begin
                // The word drained (or the register was empty) with nothing to replace it.
                // Data and channel keep their last values.
                out_valid_d = 1'b0;
            end
        end
    end

    // Resetting last_q to N_CH-1 gives channel 0 first priority after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= CH_W'(N_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_ready_onehot : assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(bus.in_ready));

    a_ready_only_valid : assert property (@(posedge clk_i) disable iff (reset_i)
        (bus.in_ready & ~bus.in_valid) == '0);

    a_hold_stable : assert property (@(posedge clk_i) disable iff (reset_i)
        (out_valid_q && !bus.out_ready) |=>
            (out_valid_q && $stable(out_data_q) && $stable(out_ch_q)));

endmodule
